// File: rtl/bus_ad_rtc_pkg.sv
// Shared definitions for the RTC multiplexed address/data bus driver.
package bus_ad_rtc_pkg;

   localparam int ANCHO_DEF = 8;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ADDR      = 3'd1,
      ADDR_HOLD = 3'd2,
      GAP       = 3'd3,
      DATA_W    = 3'd4,
      DATA_HOLD = 3'd5,
      DATA_R    = 3'd6,
      DONE      = 3'd7
   } estado_t;

   // True when the state wants the pads driven; hold states stop driving
   // in the cycle their counter has run out.
   function automatic logic conduce(input estado_t e, input logic cnt_cero);
      case (e)
         ADDR, DATA_W:         conduce = 1'b1;
         ADDR_HOLD, DATA_HOLD: conduce = ~cnt_cero;
         default:              conduce = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/bus_ad_rtc_detector_flancos.sv
// Registers a 1-bit strobe once and flags its rising and falling edges.
module detector_flancos
   import bus_ad_rtc_pkg::*;
#(
   parameter logic INIT = 1'b1
)(
   input  logic clk,
   input  logic rst,
   input  logic x,
   output logic rise,
   output logic fall
);

   logic x_p1;

   // Previous copy of the strobe; resets to the idle (inactive-high) level
   // so no spurious edge appears right after reset.
   always_ff @(posedge clk) begin
      if (rst) x_p1 <= INIT;
      else     x_p1 <= x;
   end

   assign rise = ~x_p1 & x;
   assign fall = x_p1 & ~x;

endmodule

// File: rtl/bus_ad_rtc.sv
// RTC parallel-port AD bus driver: drives address, then write data or
// captures read data, following the strobes of the signal generator.
module bus_ad_rtc
   import bus_ad_rtc_pkg::*;
#(
   parameter int ANCHO = ANCHO_DEF,
   parameter int HOLD  = 1
)(
   input  logic             reloj,
   input  logic             resetM,
   input  logic             enable_cont_32,
   input  logic             CS,
   input  logic             RD,
   input  logic             WR,
   input  logic             A_D,
   input  logic             LE,
   input  logic [ANCHO-1:0] dir,
   input  logic [ANCHO-1:0] dato_wr,
   input  logic [ANCHO-1:0] AD_in,
   output logic [ANCHO-1:0] AD_out,
   output logic             AD_oe,
   output logic [ANCHO-1:0] dato_rd,
   output logic             dato_rd_valid,
   output logic             fin_trans,
   output logic             error_trans
);

   localparam int CW = (HOLD < 1) ? 1 : $clog2(HOLD + 1);

   estado_t          estado, estado_sig;
   logic [CW-1:0]    cnt, cnt_sig;
   logic [ANCHO-1:0] dir_q, dato_wr_q;
   logic             le_q;
   logic             carga_wr, captura_rd;
   logic             rise_cs, fall_cs, rise_rd, fall_rd, rise_ad, fall_ad;
   logic             unused_sig;

   // WR carries no information beyond CS for this driver.
   assign unused_sig = ^{fall_rd, fall_ad, WR};

   detector_flancos u_det_cs (.clk(reloj), .rst(resetM), .x(CS),  .rise(rise_cs), .fall(fall_cs));
   detector_flancos u_det_rd (.clk(reloj), .rst(resetM), .x(RD),  .rise(rise_rd), .fall(fall_rd));
   detector_flancos u_det_ad (.clk(reloj), .rst(resetM), .x(A_D), .rise(rise_ad), .fall(fall_ad));

   // State and hold-counter registers.
   always_ff @(posedge reloj) begin
      if (resetM) begin
         estado <= IDLE;
         cnt    <= '0;
      end else begin
         estado <= estado_sig;
         cnt    <= cnt_sig;
      end
   end

   // Next state; a start pulse overrides whatever edge arrives with it.
   always_comb begin
      estado_sig = estado;
      cnt_sig    = cnt;
      carga_wr   = 1'b0;
      captura_rd = 1'b0;
      if (enable_cont_32) begin
         estado_sig = ADDR;
      end else begin
         case (estado)
            IDLE: estado_sig = IDLE;
            ADDR: begin
               if (rise_ad) begin
                  estado_sig = ADDR_HOLD;
                  cnt_sig    = CW'(HOLD);
               end
            end
            ADDR_HOLD: begin
               if (cnt == '0) estado_sig = GAP;
               else           cnt_sig    = cnt - CW'(1);
            end
            GAP: begin
               if (fall_cs) begin
                  if (le_q) begin
                     estado_sig = DATA_R;
                  end else begin
                     estado_sig = DATA_W;
                     carga_wr   = 1'b1;
                  end
               end
            end
            DATA_W: begin
               if (rise_cs) begin
                  estado_sig = DATA_HOLD;
                  cnt_sig    = CW'(HOLD);
               end
            end
            DATA_HOLD: begin
               if (cnt == '0) estado_sig = DONE;
               else           cnt_sig    = cnt - CW'(1);
            end
            DATA_R: begin
               if (rise_rd) begin
                  estado_sig = DONE;
                  captura_rd = 1'b1;
               end
            end
            DONE:    estado_sig = IDLE;
            default: estado_sig = IDLE;
         endcase
      end
   end

   // Holding registers, pad value, read capture and sticky abort flag.
   always_ff @(posedge reloj) begin
      if (resetM) begin
         dir_q         <= '0;
         dato_wr_q     <= '0;
         le_q          <= 1'b0;
         AD_out        <= '0;
         dato_rd       <= '0;
         dato_rd_valid <= 1'b0;
         error_trans   <= 1'b0;
      end else begin
         dato_rd_valid <= captura_rd;
         if (enable_cont_32) begin
            dir_q     <= dir;
            dato_wr_q <= dato_wr;
            le_q      <= LE;
            AD_out    <= dir;
            if (estado != IDLE) error_trans <= 1'b1;
         end
         if (carga_wr)   AD_out  <= dato_wr_q;
         if (captura_rd) dato_rd <= AD_in;
      end
   end

   // RD low means the RTC may be driving the pads, so it always wins.
   assign AD_oe     = RD & conduce(estado, cnt == '0);
   assign fin_trans = (estado == DONE);

endmodule

// File: tb/tb_bus_ad_rtc.sv
// Bench for bus_ad_rtc: one HOLD=1 and one HOLD=0 instance share stimulus.
module tb_bus_ad_rtc;

   logic       reloj = 1'b0;
   logic       resetM, enable_cont_32, CS, RD, WR, A_D, LE;
   logic [7:0] dir, dato_wr, AD_in, val_rd;

   logic [7:0] ad_out_h1, dato_rd_h1, ad_out_h0, dato_rd_h0;
   logic       oe_h1, vld_h1, fin_h1, err_h1;
   logic       oe_h0, vld_h0, fin_h0, err_h0;

   int ciclo   = 0;
   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int    cyc;
      int    sel;
      int    val;
      string tag;
   } esp_t;

   esp_t  sb[$];
   string campo[6] = '{"oe", "ad", "fin", "drd", "vld", "err"};

   always #5 reloj = ~reloj;
   always @(posedge reloj) ciclo <= ciclo + 1;

   bus_ad_rtc #(.ANCHO(8), .HOLD(1)) u_h1 (
      .reloj(reloj), .resetM(resetM), .enable_cont_32(enable_cont_32),
      .CS(CS), .RD(RD), .WR(WR), .A_D(A_D), .LE(LE),
      .dir(dir), .dato_wr(dato_wr), .AD_in(AD_in),
      .AD_out(ad_out_h1), .AD_oe(oe_h1), .dato_rd(dato_rd_h1),
      .dato_rd_valid(vld_h1), .fin_trans(fin_h1), .error_trans(err_h1)
   );

   bus_ad_rtc #(.ANCHO(8), .HOLD(0)) u_h0 (
      .reloj(reloj), .resetM(resetM), .enable_cont_32(enable_cont_32),
      .CS(CS), .RD(RD), .WR(WR), .A_D(A_D), .LE(LE),
      .dir(dir), .dato_wr(dato_wr), .AD_in(AD_in),
      .AD_out(ad_out_h0), .AD_oe(oe_h0), .dato_rd(dato_rd_h0),
      .dato_rd_valid(vld_h0), .fin_trans(fin_h0), .error_trans(err_h0)
   );

   task automatic comprobar(input string tag, input logic [31:0] obsv, input logic [31:0] expv);
      n_tests++;
      if (obsv !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obsv, expv);
      end
   endtask

   function automatic logic [7:0] obs(input int sel);
      case (sel)
         0:  return {7'd0, oe_h1};
         1:  return ad_out_h1;
         2:  return {7'd0, fin_h1};
         3:  return dato_rd_h1;
         4:  return {7'd0, vld_h1};
         5:  return {7'd0, err_h1};
         6:  return {7'd0, oe_h0};
         7:  return ad_out_h0;
         8:  return {7'd0, fin_h0};
         9:  return dato_rd_h0;
         10: return {7'd0, vld_h0};
         11: return {7'd0, err_h0};
         default: return 8'h00;
      endcase
   endfunction

   task automatic esperar(input int c, input int sel, input int v, input string nom);
      esp_t e;
      e.cyc = c;
      e.sel = sel;
      e.val = v;
      e.tag = $sformatf("%s_c%0d_%s_%s", nom, c, campo[sel % 6], (sel < 6) ? "h1" : "h0");
      sb.push_back(e);
   endtask

   // Compare every pending expectation that belongs to the current cycle.
   always @(negedge reloj) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == ciclo) begin
            comprobar(sb[i].tag, {24'd0, obs(sb[i].sel)}, sb[i].val);
            sb.delete(i);
         end
      end
   end

   // One generator cycle r of a 32-cycle transaction (r >= 32 is idle).
   task automatic paso(input int r, input bit lect);
      logic cs_v;
      @(posedge reloj);
      #1;
      cs_v           = !((r >= 2 && r <= 8) || (r >= 20 && r <= 26));
      resetM         = 1'b0;
      enable_cont_32 = (r == 0);
      A_D            = !(r >= 1 && r <= 10);
      CS             = cs_v;
      WR             = lect ? 1'b1 : cs_v;
      RD             = lect ? !(r >= 20 && r <= 26) : 1'b1;
      AD_in          = (lect && r >= 20 && r <= 27) ? val_rd : 8'hEE;
      if (r == 1) begin
         dir     = 8'hFF;
         dato_wr = 8'h00;
         LE      = ~LE;
      end
   endtask

   task automatic esperar_escritura(input int base, input int nr, input int d, input int w,
                                    input bit cont, input int err_v, input string nom);
      for (int r = 0; r < nr; r++) begin
         for (int k = 0; k < 2; k++) begin
            int c;
            int s;
            bit oe;
            c  = base + r;
            s  = k * 6;
            oe = (k == 0) ? ((r >= 1 && r <= 12) || (r >= 21 && r <= 28))
                          : ((r >= 1 && r <= 11) || (r >= 21 && r <= 27));
            if (cont && (r == 4 || r == 5)) oe = 1'b0;
            esperar(c, s + 0, int'(oe), nom);
            if (r >= 1) esperar(c, s + 1, (r <= 20) ? d : w, nom);
            esperar(c, s + 2, (r == ((k == 0) ? 30 : 29)) ? 1 : 0, nom);
            esperar(c, s + 4, 0, nom);
            if (r >= 1) esperar(c, s + 5, err_v, nom);
         end
      end
   endtask

   task automatic esperar_lectura(input int base, input int d, input int v, input string nom);
      for (int r = 0; r < 33; r++) begin
         for (int k = 0; k < 2; k++) begin
            int c;
            int s;
            bit oe;
            c  = base + r;
            s  = k * 6;
            oe = (k == 0) ? (r >= 1 && r <= 12) : (r >= 1 && r <= 11);
            esperar(c, s + 0, int'(oe), nom);
            if (r >= 1) esperar(c, s + 1, d, nom);
            esperar(c, s + 2, (r == 28) ? 1 : 0, nom);
            esperar(c, s + 4, (r == 28) ? 1 : 0, nom);
            if (r >= 28) esperar(c, s + 3, v, nom);
         end
      end
   endtask

   initial begin
      int base;
      resetM         = 1'b1;
      enable_cont_32 = 1'b0;
      CS             = 1'b1;
      RD             = 1'b1;
      WR             = 1'b1;
      A_D            = 1'b1;
      LE             = 1'b0;
      dir            = 8'h00;
      dato_wr        = 8'h00;
      AD_in          = 8'hEE;
      val_rd         = 8'h00;

      // reset state
      repeat (3) @(posedge reloj);
      #1;
      for (int s = 0; s < 12; s++) esperar(ciclo, s, 0, "reset");
      paso(40, 1'b0);
      paso(40, 1'b0);

      // write transaction
      dir = 8'h21; dato_wr = 8'h5A; LE = 1'b0;
      paso(0, 1'b0);
      base = ciclo;
      esperar_escritura(base, 33, 8'h21, 8'h5A, 1'b0, 0, "wr");
      for (int r = 1; r <= 33; r++) paso(r, 1'b0);

      // read transaction
      dir = 8'h24; LE = 1'b1; val_rd = 8'h37;
      paso(0, 1'b1);
      base = ciclo;
      esperar_lectura(base, 8'h24, 8'h37, "rd");
      for (int r = 1; r <= 33; r++) paso(r, 1'b1);

      // contention: RD forced low while in ADDR
      dir = 8'h3C; dato_wr = 8'hA5; LE = 1'b0;
      paso(0, 1'b0);
      base = ciclo;
      esperar_escritura(base, 33, 8'h3C, 8'hA5, 1'b1, 0, "cont");
      for (int r = 1; r <= 33; r++) begin
         paso(r, 1'b0);
         if (r == 4 || r == 5) RD = 1'b0;
      end

      // abort in GAP; CS falls together with the new start
      dir = 8'h21; dato_wr = 8'h5A; LE = 1'b0;
      paso(0, 1'b0);
      base = ciclo;
      esperar_escritura(base, 16, 8'h21, 8'h5A, 1'b0, 0, "abA");
      for (int r = 1; r <= 15; r++) paso(r, 1'b0);
      dir = 8'h42; dato_wr = 8'h99; LE = 1'b0;
      paso(0, 1'b0);
      CS = 1'b0;
      base = ciclo;
      esperar_escritura(base, 33, 8'h42, 8'h99, 1'b0, 1, "abB");
      for (int r = 1; r <= 33; r++) paso(r, 1'b0);

      // reset during DATA_W
      dir = 8'h11; dato_wr = 8'hA5; LE = 1'b0;
      paso(0, 1'b0);
      base = ciclo;
      esperar_escritura(base, 24, 8'h11, 8'hA5, 1'b0, 1, "rst");
      for (int r = 24; r <= 34; r++)
         for (int s = 0; s < 12; s++) esperar(base + r, s, 0, "rst");
      for (int r = 1; r <= 34; r++) begin
         paso(r, 1'b0);
         if (r == 23) resetM = 1'b1;
      end

      paso(40, 1'b0);
      paso(40, 1'b0);
      comprobar("sb_vacio", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
